// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU load/store
// path and an external boot/test port; one access in flight, MEM_LAT-cycle reads.
module dmem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ready,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int unsigned        CNT_W    = 2;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MEM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              ext_ready_q, ext_ready_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              grant_ext;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        ext_rdata_d  = ext_rdata_q;
        grant_ext    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req || ext_req) begin
                    // On a tie the port that did not go last wins
                    grant_ext = ext_req && (!cpu_req || !last_owner_q);
                    owner_d   = grant_ext;
                    we_d      = grant_ext ? ext_we    : cpu_we;
                    addr_d    = grant_ext ? ext_addr  : cpu_addr;
                    wdata_d   = grant_ext ? ext_wdata : cpu_wdata;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    if (owner_q) ext_rdata_d = mem_rdata;
                    else         cpu_rdata_d = mem_rdata;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        mem_en_d    = (state_d == S_ACCESS);
        mem_we_d    = (state_d == S_ACCESS) && we_d;
        cpu_ready_d = (state_d == S_DONE) && !owner_d;
        ext_ready_d = (state_d == S_DONE) && owner_d;
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            cpu_rdata_q  <= '0;
            ext_rdata_q  <= '0;
            cpu_ready_q  <= 1'b0;
            ext_ready_q  <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ext_rdata_q  <= ext_rdata_d;
            cpu_ready_q  <= cpu_ready_d;
            ext_ready_q  <= ext_ready_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign ext_ready = ext_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ext_rdata = ext_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with MEM_LAT=2 and a memory model whose read
// data is valid only in the single cycle MEM_LAT cycles after the mem_en cycle.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we, ext_req, ext_we;
    logic [ADDR_W-1:0] cpu_addr, ext_addr, mem_addr;
    logic [DATA_W-1:0] cpu_wdata, ext_wdata, mem_wdata, mem_rdata;
    logic [DATA_W-1:0] cpu_rdata, ext_rdata;
    logic              cpu_ready, ext_ready, mem_en, mem_we, busy, owner;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ready(ext_ready), .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Memory model: data appears only in the exact cycle it is specified valid
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] rd_word = '0;
    int                pend    = 0;

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        if (mem_en && !mem_we) begin
            pend    <= 1;
            rd_word <= mem.exists(mem_addr) ? mem[mem_addr] : '0;
        end else if (pend == int'(MEM_LAT)) begin
            pend <= 0;
        end else if (pend != 0) begin
            pend <= pend + 1;
        end
    end

    assign mem_rdata = (pend == int'(MEM_LAT)) ? rd_word : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem[32'h20] = 32'h1234_5678;
        mem[32'h30] = 32'hA5A5_A5A5;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
        tick(); tick();

        // Reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_cpu_ready", 32'(cpu_ready), 0);
        check("rst_ext_ready", 32'(ext_ready), 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_ext_rdata", ext_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        tick();

        // CPU write alone
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
        tick();
        check("wr_mem_en", 32'(mem_en), 1);
        check("wr_mem_we", 32'(mem_we), 1);
        check("wr_mem_addr", mem_addr, 32'h10);
        check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("wr_owner", 32'(owner), 0);
        check("wr_busy", 32'(busy), 1);
        check("wr_ready_early", 32'(cpu_ready), 0);
        tick();
        check("wr_cpu_ready", 32'(cpu_ready), 1);
        check("wr_ext_ready", 32'(ext_ready), 0);
        check("wr_mem_en_done", 32'(mem_en), 0);
        cpu_req = 1'b0;
        tick();
        check("wr_no_reissue", 32'(mem_en), 0);
        check("wr_ready_once", 32'(cpu_ready), 0);
        tick();
        check("wr_idle_busy", 32'(busy), 0);
        check("wr_mem_addr_hold", mem_addr, 32'h10);

        // CPU read, MEM_LAT=2: mem_en at c+1, ready at c+4
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        tick();
        check("rd_mem_en", 32'(mem_en), 1);
        check("rd_mem_we", 32'(mem_we), 0);
        check("rd_mem_addr", mem_addr, 32'h20);
        tick();
        check("rd_wait1_ready", 32'(cpu_ready), 0);
        check("rd_wait1_mem_en", 32'(mem_en), 0);
        tick();
        check("rd_wait2_ready", 32'(cpu_ready), 0);
        tick();
        check("rd_cpu_ready", 32'(cpu_ready), 1);
        check("rd_cpu_rdata", cpu_rdata, 32'h1234_5678);
        check("rd_ext_rdata", ext_rdata, 0);
        check("rd_ext_ready", 32'(ext_ready), 0);
        cpu_req = 1'b0;
        tick();
        check("rd_idle_busy", 32'(busy), 0);

        // Both requests held out of reset: CPU, EXT, CPU, EXT
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1111_0000;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h50; ext_wdata = 32'h2222_0000;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_mem_en", 32'(mem_en), 1);
            check("rr_owner", 32'(owner), 32'(i % 2));
            check("rr_mem_addr", mem_addr, (i % 2 == 0) ? 32'h40 : 32'h50);
            tick();
            check("rr_cpu_ready", 32'(cpu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_ext_ready", 32'(ext_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i == 3) begin
                cpu_req = 1'b0;
                ext_req = 1'b0;
            end
            tick();
            check("rr_idle", 32'(busy), 0);
        end
        tick();
        check("rr_quiet", 32'(mem_en), 0);

        // EXT read with inputs disturbed after grant, then CPU write
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h30;
        tick();
        check("ext_mem_en", 32'(mem_en), 1);
        check("ext_owner", 32'(owner), 1);
        ext_req = 1'b0; ext_addr = 32'h99; ext_we = 1'b1;
        tick();
        check("ext_addr_latched", mem_addr, 32'h30);
        tick();
        tick();
        check("ext_ready", 32'(ext_ready), 1);
        check("ext_rdata", ext_rdata, 32'hA5A5_A5A5);
        check("ext_cpu_ready", 32'(cpu_ready), 0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h60; cpu_wdata = 32'h0BAD_F00D;
        tick();
        check("done_no_eval", 32'(mem_en), 0);
        tick();
        check("cw_mem_en", 32'(mem_en), 1);
        check("cw_owner", 32'(owner), 0);
        tick();
        check("cw_cpu_ready", 32'(cpu_ready), 1);
        check("cw_ext_rdata_hold", ext_rdata, 32'hA5A5_A5A5);
        check("cw_cpu_rdata_hold", cpu_rdata, 0);
        cpu_req = 1'b0;
        tick();

        // Reset during WAIT of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        tick();
        check("rw_mem_en", 32'(mem_en), 1);
        tick();
        rst = 1'b1;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h80; ext_wdata = 32'h5;
        tick();
        check("rw_busy", 32'(busy), 0);
        check("rw_mem_en", 32'(mem_en), 0);
        check("rw_cpu_ready", 32'(cpu_ready), 0);
        check("rw_cpu_rdata", cpu_rdata, 0);
        check("rw_ext_rdata", ext_rdata, 0);
        rst = 1'b0;
        cpu_we = 1'b1; cpu_addr = 32'h70; cpu_wdata = 32'h7;
        tick();
        check("rw_tie_owner", 32'(owner), 0);
        check("rw_tie_mem_en", 32'(mem_en), 1);
        check("rw_no_ready", 32'(cpu_ready), 0);
        tick();
        check("rw_cpu_ready2", 32'(cpu_ready), 1);
        cpu_req = 1'b0;
        tick();
        tick();
        check("ext_next_owner", 32'(owner), 1);
        check("ext_next_addr", mem_addr, 32'h80);
        tick();
        check("ext_next_ready", 32'(ext_ready), 1);

        // EXT keeps req high past ready: exactly one new access
        tick();
        check("hold_idle", 32'(busy), 0);
        tick();
        check("hold_mem_en", 32'(mem_en), 1);
        check("hold_owner", 32'(owner), 1);
        ext_req = 1'b0;
        tick();
        check("hold_ready", 32'(ext_ready), 1);
        tick();
        tick();
        check("hold_no_more", 32'(mem_en), 0);
        check("hold_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the processor's load/store path and an external port used for boot loading and test access. Each requester issues a level-held request. The block grants one requester at a time using round-robin on ties. It sequences a single memory access with a parameterised read latency, then returns read data with a one-cycle ready pulse. It sits between the multicycle core's MemRead/MemWrite/dAddress/dWriteData/dReadData signals and the data memory.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MEM_LAT, 1, memory read latency in cycles (legal 1..4); mem_rdata is valid MEM_LAT cycles after the mem_en cycle

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset; synchronous, active-high
cpu_req  in  1  CPU access request, held high until cpu_ready
cpu_we  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ready  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  DATA_W  registered read data for CPU
ext_req  in  1  external request, same rules as cpu_req
ext_we  in  1  external write enable
ext_addr  in  ADDR_W  external address
ext_wdata  in  DATA_W  external write data
ext_ready  out  1  one-cycle completion pulse to external port
ext_rdata  out  DATA_W  registered read data for external port
mem_en  out  1  memory access strobe, exactly one cycle per access
mem_we  out  1  memory write enable, only valid with mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  1 in any state other than IDLE
owner  out  1  current grant: 0=CPU, 1=EXT; meaningful when busy=1

Behaviour:
- Reset values: state=IDLE; all outputs 0; cpu_rdata/ext_rdata=0; last_owner=EXT, so the CPU wins the first tie.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_owner.
  - On grant: latch owner, we, addr and wdata into registers; go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS (1 cycle):
  - mem_en=1; mem_we=latched we; mem_addr/mem_wdata come from the latched registers.
  - A write goes to DONE. A read goes to WAIT and clears the latency counter.
- WAIT:
  - Counter increments each cycle.
  - When counter==MEM_LAT-1, capture mem_rdata into the owner's rdata register at that edge and go to DONE.
  - This gives exactly MEM_LAT cycles in WAIT.
- DONE (1 cycle):
  - Owner's ready=1; last_owner<=owner; next state is IDLE.
  - Requests are not evaluated in DONE.
- Requester protocol:
  - The requester must drop req in the cycle after ready, so a completed request is never re-granted.
  - A req still high in IDLE is treated as a new access.
- Latency, with req first sampled in IDLE at cycle c:
  - Write: mem_en at c+1, ready at c+2.
  - Read: mem_en at c+1, ready at c+MEM_LAT+2.
- Outputs outside ACCESS:
  - mem_en=0 and mem_we=0 outside ACCESS.
  - mem_addr and mem_wdata hold their last latched value.
- Read data and ready ownership:
  - The non-owner's ready stays 0.
  - rdata registers are updated only by that port's own reads.
  - rdata holds its value across writes and across the other port's accesses.
- Request changes after grant: input changes after grant (addr, we, wdata, req drop) do not affect an in-flight access.
- Fairness: with both reqs held continuously, grants alternate CPU, EXT, CPU, and so on. Neither port waits more than one foreign access.
- Reset mid-operation: returns to IDLE on the next edge. No ready pulse is issued, mem_en is deasserted, and rdata is cleared.
- Addresses are passed through unmodified; no alignment check.

Test Plan:
- CPU write alone, addr=0x10, wdata=0xDEADBEEF → mem_en=1/mem_we=1 with those values one cycle after req; cpu_ready pulse the following cycle; ext_ready stays 0.
- MEM_LAT=2, CPU read addr=0x20, memory returns 0x12345678 → mem_en at c+1; cpu_ready at c+4 with cpu_rdata=0x12345678; ext_rdata unchanged.
- Both reqs rise together out of reset and are held → grant order CPU, EXT, CPU, EXT across 4 accesses; owner matches each grant.
- EXT read completes (ext_rdata=0xA5A5A5A5), then CPU write → ext_rdata remains 0xA5A5A5A5; cpu_rdata remains 0.
- rst asserted during WAIT of a read → next cycle state IDLE, busy=0, mem_en=0, no ready pulse, rdata=0; CPU wins the next tie.
- Requester drops req in the cycle after ready → no second mem_en. Requester keeps req high → exactly one new access begins from IDLE.
